// File: rtl/seg_scan_pkg.sv
// rtl/seg_scan_pkg.sv - shared constants and types for the seven-segment scan controller
package seg_scan_pkg;

    localparam int NUM_DIGITS = 8;
    localparam int CHAR_W     = 5;

    localparam logic [CHAR_W-1:0] CHAR_BLANK = '0;

    typedef enum logic {
        BLANK = 1'b0,
        ON    = 1'b1
    } scan_state_t;

endpackage

// File: rtl/scan_prescaler.sv
// rtl/scan_prescaler.sv - slot-rate prescaler with per-slot blanking window
module scan_prescaler #(
    parameter int DIV          = 16,
    parameter int BLANK_CYCLES = 4,
    localparam int CNT_W       = (DIV < 2) ? 1 : $clog2(DIV)
) (
    input  logic             clk,
    input  logic             reset_n,
    output logic [CNT_W-1:0] slot_cnt,
    output logic             slot_end,
    output logic             in_blank
);

    if (DIV < 2 || BLANK_CYCLES < 0 || BLANK_CYCLES >= DIV) begin : g_bad_params
        $error("scan_prescaler: need DIV >= 2 and 0 <= BLANK_CYCLES < DIV");
    end

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYCLES);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Free-running slot counter, 0..DIV-1.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign slot_cnt = cnt_q;
    assign slot_end = (cnt_q == CNT_LAST);
    assign in_blank = (cnt_q < BLANK_LIM);

endmodule

// File: rtl/seg_scan_controller.sv
// rtl/seg_scan_controller.sv - 8-digit multiplexed display scanner with PWM and double-buffered frames
module seg_scan_controller
    import seg_scan_pkg::*;
#(
    parameter int CLK_HZ       = 100_000_000,
    parameter int SCAN_HZ      = 1000,
    parameter int BLANK_CYCLES = 64
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         frame_valid,
    output logic                         frame_ready,
    input  logic [NUM_DIGITS*CHAR_W-1:0] frame_data,
    input  logic [NUM_DIGITS-1:0]        frame_mask,
    input  logic [3:0]                   brightness,
    output logic [NUM_DIGITS-1:0]        anode_n,
    output logic [CHAR_W-1:0]            char_code,
    output logic [2:0]                   digit_idx,
    output logic                         scan_wrap
);

    localparam int DIV       = CLK_HZ / SCAN_HZ;
    localparam int CNT_W     = (DIV < 2) ? 1 : $clog2(DIV);
    localparam bit HAS_BLANK = (BLANK_CYCLES > 0);
    localparam logic [CNT_W-1:0] BLANK_LAST = HAS_BLANK ? CNT_W'(BLANK_CYCLES - 1) : '0;
    localparam logic [2:0]       DIGIT_LAST = 3'(NUM_DIGITS - 1);

    logic [CNT_W-1:0] slot_cnt;
    logic             slot_end;
    logic             in_blank;

    scan_state_t state_q, state_d;
    logic [3:0]  pwm_q, pwm_d;
    logic [2:0]  digit_q, digit_d;
    logic        pending_q, pending_d;
    logic [NUM_DIGITS-1:0] anode_q, anode_d;

    logic [NUM_DIGITS*CHAR_W-1:0] shadow_frame_q, active_frame_q, active_frame_d;
    logic [NUM_DIGITS-1:0]        shadow_mask_q, active_mask_q, active_mask_d;

    logic accept;
    logic swap;

    scan_prescaler #(
        .DIV          (DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_prescaler (
        .clk      (clk),
        .reset_n  (reset_n),
        .slot_cnt (slot_cnt),
        .slot_end (slot_end),
        .in_blank (in_blank)
    );

    assign scan_wrap = slot_end && (digit_q == DIGIT_LAST);
    assign accept    = frame_valid && !pending_q;
    assign swap      = scan_wrap && pending_q;

    // Next-state: phase/digit/PWM for the coming cycle, buffer swap, and the anode
    // pattern that those next values produce (so anode_n can be a plain register).
    always_comb begin
        state_d        = state_q;
        pwm_d          = pwm_q + 4'd1;
        digit_d        = digit_q;
        pending_d      = pending_q;
        active_frame_d = active_frame_q;
        active_mask_d  = active_mask_q;
        anode_d        = '1;

        if (slot_end) begin
            digit_d = (digit_q == DIGIT_LAST) ? 3'd0 : digit_q + 3'd1;
            state_d = HAS_BLANK ? BLANK : ON;
        end else if (HAS_BLANK && slot_cnt == BLANK_LAST) begin
            state_d = ON;
        end else begin
            state_d = in_blank ? BLANK : ON;
        end

        if (state_q == BLANK && state_d == ON) begin
            pwm_d = 4'd0;
        end

        if (swap) begin
            active_frame_d = shadow_frame_q;
            active_mask_d  = shadow_mask_q;
            pending_d      = 1'b0;
        end else if (accept) begin
            pending_d = 1'b1;
        end

        if (state_d == ON && active_mask_d[digit_d] && pwm_d <= brightness) begin
            anode_d[digit_d] = 1'b0;
        end
    end

    // Scan state, PWM phase and registered anode drive.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= BLANK;
            pwm_q     <= '0;
            digit_q   <= '0;
            pending_q <= 1'b0;
            anode_q   <= '1;
        end else begin
            state_q   <= state_d;
            pwm_q     <= pwm_d;
            digit_q   <= digit_d;
            pending_q <= pending_d;
            anode_q   <= anode_d;
        end
    end

    // Shadow captures on handshake; active is only ever loaded from the shadow.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow_frame_q <= {NUM_DIGITS{CHAR_BLANK}};
            shadow_mask_q  <= '0;
            active_frame_q <= {NUM_DIGITS{CHAR_BLANK}};
            active_mask_q  <= '0;
        end else begin
            if (accept) begin
                shadow_frame_q <= frame_data;
                shadow_mask_q  <= frame_mask;
            end
            active_frame_q <= active_frame_d;
            active_mask_q  <= active_mask_d;
        end
    end

    assign frame_ready = !pending_q;
    assign anode_n     = anode_q;
    assign digit_idx   = digit_q;
    assign char_code   = active_frame_q[32'(digit_q) * CHAR_W +: CHAR_W];

endmodule

// File: tb/tb_seg_scan_controller.sv
// tb/tb_seg_scan_controller.sv - scoreboard bench for seg_scan_controller
module tb_seg_scan_controller;
    import seg_scan_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        frame_valid = 1'b0;
    logic        frame_ready;
    logic [39:0] frame_data = '0;
    logic [7:0]  frame_mask = '0;
    logic [3:0]  brightness = 4'd15;
    logic [7:0]  anode_n;
    logic [4:0]  char_code;
    logic [2:0]  digit_idx;
    logic        scan_wrap;

    always #5 clk = ~clk;

    seg_scan_controller #(
        .CLK_HZ       (1600),
        .SCAN_HZ      (100),
        .BLANK_CYCLES (4)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .frame_data  (frame_data),
        .frame_mask  (frame_mask),
        .brightness  (brightness),
        .anode_n     (anode_n),
        .char_code   (char_code),
        .digit_idx   (digit_idx),
        .scan_wrap   (scan_wrap)
    );

    typedef struct {
        logic [7:0] anode;
        logic [4:0] code;
        logic [2:0] idx;
        logic       wrap;
        logic       ready;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: time since reset determines slot and digit; frames follow
    // the shadow/active double-buffer rules.
    int unsigned k = 0;
    logic        m_pending = 1'b0;
    logic [39:0] m_shadow = '0;
    logic [39:0] m_active = '0;
    logic [7:0]  m_smask = '0;
    logic [7:0]  m_amask = '0;
    logic        m_last_accept = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(posedge clk) begin : model
        exp_t e;
        int   pos;
        int   dig;
        m_last_accept = 1'b0;
        if (!reset_n) begin
            k         = 0;
            m_pending = 1'b0;
            m_shadow  = '0;
            m_active  = '0;
            m_smask   = '0;
            m_amask   = '0;
        end else begin
            if ((k % 128) == 127 && m_pending) begin
                m_active  = m_shadow;
                m_amask   = m_smask;
                m_pending = 1'b0;
            end else if (frame_valid && !m_pending) begin
                m_shadow      = frame_data;
                m_smask       = frame_mask;
                m_pending     = 1'b1;
                m_last_accept = 1'b1;
            end
            k = k + 1;
        end
        pos     = int'(k % 16);
        dig     = int'((k / 16) % 8);
        e.anode = 8'hFF;
        if (pos >= 4 && m_amask[dig] && (pos - 4) <= int'(brightness)) begin
            e.anode[dig] = 1'b0;
        end
        e.code  = m_active[dig*5 +: 5];
        e.idx   = dig[2:0];
        e.wrap  = (pos == 15 && dig == 7);
        e.ready = !m_pending;
        exp_q.push_back(e);
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (!reset_n) begin
                e.anode = 8'hFF;
                e.code  = CHAR_BLANK;
                e.idx   = 3'd0;
                e.wrap  = 1'b0;
                e.ready = 1'b1;
            end
            check("anode_n",     32'(anode_n),     32'(e.anode));
            check("char_code",   32'(char_code),   32'(e.code));
            check("digit_idx",   32'(digit_idx),   32'(e.idx));
            check("scan_wrap",   32'(scan_wrap),   32'(e.wrap));
            check("frame_ready", 32'(frame_ready), 32'(e.ready));
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic send_frame(input logic [39:0] d, input logic [7:0] m);
        bit ok;
        ok          = 1'b0;
        frame_valid = 1'b1;
        frame_data  = d;
        frame_mask  = m;
        for (int i = 0; i < 1000 && !ok; i++) begin
            step();
            ok = m_last_accept;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL frame_accept at t=%0t: got no acceptance expected acceptance within 1000 cycles", $time);
        end
        frame_valid      = 1'b0;
        frame_data[31:0] = $urandom();
        frame_mask       = 8'($urandom());
    endtask

    function automatic logic [39:0] counting_frame();
        logic [39:0] d;
        for (int i = 0; i < 8; i++) d[i*5 +: 5] = 5'(i);
        return d;
    endfunction

    function automatic logic [39:0] random_frame();
        logic [39:0] d;
        d[31:0]  = $urandom();
        d[39:32] = 8'($urandom());
        return d;
    endfunction

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog at t=%0t: got no finish expected finish before time limit", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        run(3);
        reset_n = 1'b1;

        // Idle: no frame, dark display, scan_wrap every 128 cycles.
        run(256);

        // Codes 0..7, all digits, full brightness.
        brightness = 4'd15;
        send_frame(counting_frame(), 8'hFF);
        run(300);

        // Partial duty, then randomized brightness every cycle.
        brightness = 4'd3;
        run(128);
        for (int i = 0; i < 256; i++) begin
            brightness = 4'($urandom_range(0, 15));
            step();
        end

        // Only digits 0 and 2 enabled.
        brightness = 4'd15;
        send_frame(counting_frame(), 8'b0000_0101);
        run(300);

        // Back-to-back frames A and B: B waits for A's swap.
        send_frame(random_frame(), 8'($urandom()));
        send_frame(random_frame(), 8'($urandom()));
        run(300);

        // Valid asserted on the exact scan_wrap cycle with nothing pending.
        for (int i = 0; i < 400 && !((k % 128) == 127 && !m_pending); i++) step();
        send_frame(random_frame(), 8'hFF);
        run(300);

        // Random frames, masks, brightness and idle gaps.
        for (int n = 0; n < 6; n++) begin
            brightness = 4'($urandom_range(0, 15));
            run($urandom_range(0, 150));
            send_frame(random_frame(), 8'($urandom()));
        end
        run(300);

        // Reset at slot cycle 9 of a lit slot: anode_n must go dark without a clock edge.
        brightness = 4'd15;
        send_frame(counting_frame(), 8'hFF);
        run(300);
        for (int i = 0; i < 64 && (k % 16) != 9; i++) step();
        #1;
        reset_n = 1'b0;
        #1;
        check("async_reset_anode_n", 32'(anode_n), 32'hFF);
        check("async_reset_char_code", 32'(char_code), 32'(CHAR_BLANK));
        run(3);
        reset_n = 1'b1;
        run(256);
        send_frame(counting_frame(), 8'hFF);
        run(300);

        run(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
